// File: rtl/register_file.sv
// rtl/register_file.sv - RV32I integer register file with committed-write counter
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file #(
  parameter int XLEN        = 32,
  parameter int NUM_REGS    = 32,
  parameter int COUNT_WIDTH = 32,
  localparam int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDX_W-1:0]       rs1_index,
  input  logic [IDX_W-1:0]       rs2_index,
  input  logic [IDX_W-1:0]       rd_index,
  input  logic                   rd_write_control,
  input  logic [XLEN-1:0]        rd_write_val,
  output logic [XLEN-1:0]        rs1_val,
  output logic [XLEN-1:0]        rs2_val,
  output logic [COUNT_WIDTH-1:0] write_count,
  output logic                   x0_write_attempt
);

  logic [XLEN-1:0] regs [0:NUM_REGS-1];

  logic rd_is_x0;
  logic wr_commit;
  logic x0_hit;

  assign rd_is_x0  = (rd_index == '0);
  assign wr_commit = !rst && rd_write_control && !rd_is_x0;
  assign x0_hit    = !rst && rd_write_control && rd_is_x0;

  // regs[0] is cleared on reset and never written, so x0 stays zero in storage too
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      write_count      <= '0;
      x0_write_attempt <= 1'b0;
    end else begin
      if (wr_commit) begin
        regs[rd_index] <= rd_write_val;
        write_count    <= write_count + COUNT_WIDTH'(1);
      end
      x0_write_attempt <= x0_hit;
    end
  end

  logic [XLEN-1:0] rs1_stored;
  logic [XLEN-1:0] rs2_stored;

  always_comb begin
    rs1_stored = '0;
    rs2_stored = '0;
    if (rs1_index != '0) rs1_stored = regs[rs1_index];
    if (rs2_index != '0) rs2_stored = regs[rs2_index];
  end

`ifdef REGFILE_BYPASS_EN
  // wr_commit already excludes x0 and reset, so a forwarded value is never 0-index data
  always_comb begin
    rs1_val = rs1_stored;
    rs2_val = rs2_stored;
    if (wr_commit && (rs1_index == rd_index)) rs1_val = rd_write_val;
    if (wr_commit && (rs2_index == rd_index)) rs2_val = rd_write_val;
  end
`else
  always_comb begin
    rs1_val = rs1_stored;
    rs2_val = rs2_stored;
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file against a behavioural model
module tb_register_file;

  localparam int XLEN = 32;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [4:0]      rs1_index = '0;
  logic [4:0]      rs2_index = '0;
  logic [4:0]      rd_index = '0;
  logic            rd_write_control = 1'b0;
  logic [XLEN-1:0] rd_write_val = '0;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [CW-1:0]   write_count;
  logic            x0_write_attempt;

  register_file #(.XLEN(XLEN), .NUM_REGS(32), .COUNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .rs1_index        (rs1_index),
    .rs2_index        (rs2_index),
    .rd_index         (rd_index),
    .rd_write_control (rd_write_control),
    .rd_write_val     (rd_write_val),
    .rs1_val          (rs1_val),
    .rs2_val          (rs2_val),
    .write_count      (write_count),
    .x0_write_attempt (x0_write_attempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          cnt;
    logic        x0a;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model: architectural state as plain arrays and integers
  logic [31:0] m_regs [32];
  int          m_cnt = 0;
  logic        m_x0a = 1'b0;

  function automatic logic [31:0] model_read(input int idx, input bit r, input bit we,
                                             input int rd, input logic [31:0] val);
    if (idx == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (!r && we && rd == idx) return val;
`endif
    return m_regs[idx];
  endfunction

  task automatic step(input bit r, input bit we, input int rd, input logic [31:0] val,
                      input int a, input int b, input bit chk, input string tag);
    exp_t e;
    rst              = r;
    rd_write_control = we;
    rd_index         = 5'(rd);
    rd_write_val     = val;
    rs1_index        = 5'(a);
    rs2_index        = 5'(b);
    if (chk) begin
      e.rs1 = model_read(a, r, we, rd, val);
      e.rs2 = model_read(b, r, we, rd, val);
      e.cnt = m_cnt;
      e.x0a = m_x0a;
      e.tag = tag;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 0;
      m_x0a = 1'b0;
    end else begin
      m_x0a = we && (rd == 0);
      if (we && rd != 0) begin
        m_regs[rd] = val;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end
    #1;
  endtask

  // monitor: the DUT presents a fresh combinational result every cycle; compare mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (rs1_val !== e.rs1) begin
          n_fail++;
          $display("FAIL %s rs1_val: got %h expected %h", e.tag, rs1_val, e.rs1);
        end
        n_checks++;
        if (rs2_val !== e.rs2) begin
          n_fail++;
          $display("FAIL %s rs2_val: got %h expected %h", e.tag, rs2_val, e.rs2);
        end
        n_checks++;
        if (write_count !== CW'(e.cnt)) begin
          n_fail++;
          $display("FAIL %s write_count: got %0d expected %0d", e.tag, write_count, e.cnt);
        end
        n_checks++;
        if (x0_write_attempt !== e.x0a) begin
          n_fail++;
          $display("FAIL %s x0_write_attempt: got %b expected %b", e.tag, x0_write_attempt, e.x0a);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 32'h0, 0, 0, 0, "reset");
    step(1, 0, 0, 32'h0, 0, 0, 0, "reset");

    for (int i = 0; i < 32; i++) step(0, 0, 0, 32'h0, i, 31 - i, 1, "reset_sweep");

    step(0, 1, 5, 32'hDEADBEEF, 5, 5, 1, "basic_wr");
    step(0, 0, 0, 32'h0, 5, 5, 1, "basic_rd");

    step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 1, "x0_wr");
    step(0, 0, 0, 32'h0, 0, 5, 1, "x0_pulse");
    step(0, 0, 0, 32'h0, 0, 5, 1, "x0_clear");

    step(0, 1, 7, 32'h1, 0, 0, 1, "hazard_setup");
    step(0, 1, 7, 32'h2, 7, 0, 1, "hazard_same");
    step(0, 0, 0, 32'h0, 7, 7, 1, "hazard_next");

    step(0, 1, 3, 32'hA5, 3, 0, 1, "rstpri_setup");
    step(1, 1, 3, 32'h5A, 3, 7, 1, "rstpri_rst");
    step(0, 0, 0, 32'h0, 3, 7, 1, "rstpri_after");

    for (int i = 1; i <= 17; i++) step(0, 1, i, 32'h1111 * i, i, 1, 1, "wrap_wr");
    step(0, 0, 0, 32'h0, 17, 16, 1, "wrap_rd");

    for (int n = 0; n < 400; n++) begin
      bit r;
      bit we;
      int rd;
      int a;
      int b;
      r  = ($urandom_range(0, 49) == 0);
      we = ($urandom_range(0, 3) != 0);
      rd = (($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 31)));
      a  = int'($urandom_range(0, 31));
      b  = (($urandom_range(0, 3) == 0) ? rd : int'($urandom_range(0, 31)));
      if ($urandom_range(0, 2) == 0) a = rd;
      step(r, we, rd, $urandom, a, b, 1, "random");
    end

    step(0, 0, 0, 32'h0, 0, 0, 0, "idle");
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected results never checked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- RV32I integer register file: 32 x 32-bit architectural registers, x0 hardwired to zero.
- Consumer end of the ALU writeback interface: takes rd_write_control / rd_write_val plus the destination index from decode.
- Producer of the ALU operand interface: supplies rs1_val / rs2_val for the decoded source indices.
- Also keeps a counter of committed register writes for debug and performance monitoring.

Parameters:
- XLEN, 32, data width of each register and of all value ports.
- NUM_REGS, 32, number of architectural registers; index width is $clog2(NUM_REGS).
- COUNT_WIDTH, 32, width of the committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rs1_index  input  5  source register 1 index.
- rs2_index  input  5  source register 2 index.
- rd_index  input  5  destination register index for the current writeback.
- rd_write_control  input  1  writeback enable from ALU.
- rd_write_val  input  XLEN  writeback data from ALU.
- rs1_val  output  XLEN  operand 1 value for x[rs1_index].
- rs2_val  output  XLEN  operand 2 value for x[rs2_index].
- write_count  output  COUNT_WIDTH  number of committed writes since reset.
- x0_write_attempt  output  1  registered pulse: a write targeted x0 in the previous cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - all registers x1..x31 become 0;
  - write_count becomes 0;
  - x0_write_attempt becomes 0.
  - rst has priority over a same-cycle write; that write is dropped and not counted.
- Write:
  - At a clk edge with rst=0, rd_write_control=1 and rd_index!=0: x[rd_index] <= rd_write_val and write_count increments by 1.
  - Write latency is 1 cycle. The new value is visible on the read ports from the cycle after the edge.
- x0 writes:
  - rd_write_control=1 with rd_index=0: storage is unchanged and write_count is unchanged.
  - x0_write_attempt=1 for exactly the next cycle, then clears unless repeated.
- Reads:
  - Combinational, zero latency.
  - rs1_val = (rs1_index==0) ? 0 : x[rs1_index]; rs2_val uses the same rule with rs2_index.
  - Both ports may address the same register simultaneously; both return the same value.
- Same-cycle read/write of the same index: governed by the optional feature below.
  - Reads of index 0 always return 0 regardless of a same-cycle write to 0.
- write_count:
  - Unsigned; wraps from 2^COUNT_WIDTH-1 to 0 with no saturation and no flag.
- rd_write_control=0: rd_index and rd_write_val are don't-care and have no effect.
- Reset mid-stream: writes issued in the reset cycle are lost. The first write accepted is the one presented on the cycle after rst deasserts.
- No X propagation: every register has a defined value after one reset cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-to-read forwarding): if rd_write_control=1, rd_index!=0 and rsN_index==rd_index in the same cycle, rsN_val = rd_write_val combinationally. Forwarding is independent per read port. With rst=1 asserted, no forwarding occurs and reads return stored values.
- Undefined: same-cycle read of the index being written returns the old stored value; the new value appears the following cycle.

Test Plan:
- Reset then read: assert rst for 1 cycle, sweep rs1_index/rs2_index over 0..31 -> all reads 0, write_count=0, x0_write_attempt=0.
- Basic write/read: write x5=32'hDEADBEEF, then next cycle rs1_index=5, rs2_index=5 -> both 32'hDEADBEEF, write_count=1.
- x0 protection: write x0=32'hFFFFFFFF -> next cycle rs1_val(0)=0, write_count unchanged, x0_write_attempt=1 for one cycle, then 0.
- Same-cycle hazard: x7 holds 32'h1; in one cycle write x7=32'h2 while rs1_index=7 -> rs1_val=32'h2 with REGFILE_BYPASS_EN, 32'h1 without; next cycle 32'h2 in both builds.
- Reset priority: x3 holds 32'hA5; assert rst together with a write x3=32'h5A -> next cycle x3=0 and write_count=0.
- Counter wrap: COUNT_WIDTH=4, issue 17 writes to x1..x17 -> write_count=1 after the 17th write; x17 reads back its last value.
